// File: rtl/truss_timeout_pkg.sv
// rtl/truss_timeout_pkg.sv - shared state encoding for the truss timeout monitor
package truss_timeout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_HUNG  = 3'd4
    } state_t;

    // DONE and HUNG never leave until reset
    function automatic logic is_terminal(state_t s);
        return (s == ST_DONE) || (s == ST_HUNG);
    endfunction

endpackage

// File: rtl/truss_sync.sv
// rtl/truss_sync.sv - N-stage level synchronizer with asynchronous reset to 0
module truss_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;

    // shift the asynchronous level through N flops before anyone looks at it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else if (N > 1) begin
            sync_q <= {sync_q[N-2:0], d};
        end else begin
            sync_q <= {N{d}};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/truss_timeout_monitor.sv
// rtl/truss_timeout_monitor.sv - graceful-shutdown handshake driven by the watchdog timeout level
import truss_timeout_pkg::*;

module truss_timeout_monitor #(
    parameter int SYNC_STAGES  = 2,
    parameter int ACK_TIMEOUT  = 1000,
    parameter int DRAIN_CYCLES = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timeout_in,
    input  logic             test_done,
    output logic             shutdown_req,
    input  logic             shutdown_ack,
    output logic             drain_active,
    output logic             done_ok,
    output logic             hang_detected,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] latency_cycles
);

    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (ACK_TIMEOUT < 1 || longint'(ACK_TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_chk_ack
        $error("ACK_TIMEOUT must be in [1, 2**CNT_W)");
    end
    if (DRAIN_CYCLES < 1 || longint'(DRAIN_CYCLES) >= (longint'(1) << CNT_W)) begin : g_chk_drain
        $error("DRAIN_CYCLES must be in [1, 2**CNT_W)");
    end

    logic             timeout_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] latency_q, latency_d;

    truss_sync #(.N(SYNC_STAGES)) u_timeout_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (timeout_in),
        .q     (timeout_s)
    );

    // next-state, counter and latency capture; counters restart on any state change
    always_comb begin
        state_d     = state_q;
        ack_cnt_d   = ack_cnt_q;
        drain_cnt_d = drain_cnt_q;
        latency_d   = latency_q;
        case (state_q)
            ST_IDLE: begin
                if (timeout_s) begin
                    state_d = ST_REQ;
                end else if (test_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                if (shutdown_ack) begin
                    state_d   = ST_DRAIN;
                    latency_d = (ack_cnt_q == CNT_MAX) ? CNT_MAX : ack_cnt_q + 1'b1;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = ST_HUNG;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_DONE, ST_HUNG: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            ack_cnt_d   = '0;
            drain_cnt_d = '0;
        end
    end

    // state, counters and outputs; outputs decode the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ack_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            latency_q     <= '0;
            shutdown_req  <= 1'b0;
            drain_active  <= 1'b0;
            done_ok       <= 1'b0;
            hang_detected <= 1'b0;
        end else begin
            state_q       <= state_d;
            ack_cnt_q     <= ack_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            latency_q     <= latency_d;
            shutdown_req  <= (state_d == ST_REQ);
            drain_active  <= (state_d == ST_DRAIN);
            done_ok       <= (state_d == ST_DONE);
            hang_detected <= (state_d == ST_HUNG);
        end
    end

    assign state          = state_q;
    assign latency_cycles = latency_q;

endmodule

// File: tb/tb_truss_timeout_monitor.sv
// tb/tb_truss_timeout_monitor.sv - self-checking bench for truss_timeout_monitor
module tb_truss_timeout_monitor;

    localparam int SYNC    = 2;
    localparam int ACK_T   = 8;
    localparam int DRAIN_C = 64;
    localparam int CW      = 16;
    localparam int NONE    = 1000000;
    localparam int MAXK    = 127;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          timeout_in = 1'b0;
    logic          test_done = 1'b0;
    logic          shutdown_req;
    logic          shutdown_ack = 1'b0;
    logic          drain_active;
    logic          done_ok;
    logic          hang_detected;
    logic [2:0]    state;
    logic [CW-1:0] latency_cycles;

    int   vectors = 0;
    int   miscompares = 0;
    int   t_g = NONE;
    int   d_g = NONE;
    bit   ack_at [0:MAXK];
    logic [22:0] obs, expv;

    truss_timeout_monitor #(
        .SYNC_STAGES  (SYNC),
        .ACK_TIMEOUT  (ACK_T),
        .DRAIN_CYCLES (DRAIN_C),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .timeout_in     (timeout_in),
        .test_done      (test_done),
        .shutdown_req   (shutdown_req),
        .shutdown_ack   (shutdown_ack),
        .drain_active   (drain_active),
        .done_ok        (done_ok),
        .hang_detected  (hang_detected),
        .state          (state),
        .latency_cycles (latency_cycles)
    );

    always #5 clk = ~clk;

    // Expected outputs after edge k, from the scenario timeline:
    // timeout first sampled at edge t_g, seen by the FSM at edge r = t_g + SYNC;
    // test_done wins only if sampled before r; first ack in (r, r+ACK_T] starts drain.
    function automatic logic [22:0] model(int k);
        int r;
        int a;
        logic [2:0]    st;
        logic [CW-1:0] lat;
        st  = 3'd0;
        lat = '0;
        a   = NONE;
        r   = (t_g == NONE) ? NONE : t_g + SYNC;
        if (d_g < r) begin
            st = (k >= d_g) ? 3'd3 : 3'd0;
        end else if (k >= r) begin
            for (int e = r + 1; e <= r + ACK_T && e <= MAXK; e++) begin
                if (ack_at[e] && a == NONE) a = e;
            end
            if (a == NONE) begin
                st = (k < r + ACK_T) ? 3'd1 : 3'd4;
            end else begin
                st = (k < a) ? 3'd1 : (k < a + DRAIN_C) ? 3'd2 : 3'd3;
                if (k >= a) lat = CW'(a - r);
            end
        end
        return {st, st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4, lat};
    endfunction

    task automatic set_scenario(int t, int d);
        t_g = t;
        d_g = d;
        foreach (ack_at[i]) ack_at[i] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        timeout_in   = 1'b0;
        test_done    = 1'b0;
        shutdown_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sample();
        obs = {state, shutdown_req, drain_active, done_ok, hang_detected, latency_cycles};
    endtask

    // drive inputs for edge k, step one clock, sample just after the edge
    task automatic drive(int k);
        timeout_in   = (k >= t_g);
        test_done    = (k >= d_g);
        shutdown_ack = (k <= MAXK) ? ack_at[k] : 1'b0;
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        sample();
        vectors++;
        if (obs !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", obs, 23'd0);
        end
    endtask

    task automatic test_timeout_ack();
        apply_reset();
        set_scenario(10, NONE);
        ack_at[17] = 1'b1;
        for (int k = 1; k <= 86; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL timeout_ack k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
        vectors++;
        if (latency_cycles !== 16'd5 || done_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_ack_final latency=%0d done_ok=%b exp latency=5 done_ok=1",
                     latency_cycles, done_ok);
        end
    endtask

    task automatic test_done_first();
        apply_reset();
        set_scenario(40, 20);
        ack_at[45] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL done_first k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
    endtask

    task automatic test_hang();
        apply_reset();
        set_scenario(4, NONE);
        ack_at[15] = 1'b1;
        ack_at[17] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL hang k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
    endtask

    task automatic test_ack_last_cycle();
        apply_reset();
        set_scenario(2, NONE);
        ack_at[12] = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL ack_last_cycle k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        set_scenario(5, 7);
        ack_at[10] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL same_cycle k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
    endtask

    task automatic test_ack_idle();
        apply_reset();
        set_scenario(6, NONE);
        ack_at[2]  = 1'b1;
        ack_at[3]  = 1'b1;
        ack_at[8]  = 1'b1;
        ack_at[11] = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL ack_idle k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        set_scenario(3, NONE);
        ack_at[8] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL mid_drain_pre k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
        shutdown_ack = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        sample();
        vectors++;
        if (obs !== 23'd0) begin
            miscompares++;
            $display("FAIL mid_drain_reset got=%h exp=%h", obs, 23'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_scenario(1, NONE);
        ack_at[6] = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            drive(k);
            expv = model(k);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL mid_drain_post k=%0d got=%h exp=%h", k, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        int mode;
        for (int it = 0; it < 30; it++) begin
            apply_reset();
            set_scenario(int'($urandom_range(1, 15)),
                         ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : NONE);
            mode = int'($urandom_range(0, 3));
            for (int e = 1; e <= MAXK; e++) begin
                ack_at[e] = (mode != 0) && ($urandom_range(0, 5) == 0);
            end
            for (int k = 1; k <= 95; k++) begin
                drive(k);
                expv = model(k);
                vectors++;
                if (obs !== expv) begin
                    miscompares++;
                    $display("FAIL random it=%0d t=%0d d=%0d k=%0d got=%h exp=%h",
                             it, t_g, d_g, k, obs, expv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timeout_ack();
        test_done_first();
        test_hang();
        test_ack_last_cycle();
        test_same_cycle();
        test_ack_idle();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
